// File: rtl/channel_arbiter.sv
// channel_arbiter: round-robin owner of one shared interposer channel; drives each node's
// send/receive/bypass/idle control. Optional saturating grant counter under ARB_STATS_EN.
module channel_arbiter #(
    parameter int unsigned NUM_NODES   = 8,
    parameter int unsigned ID_W        = 3,
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_NODES*(ID_W+1)-1:0] req_in,
    output logic [NUM_NODES*3-1:0]        ctrl_out,
    output logic                          busy,
    output logic [ID_W-1:0]               grant_src,
    output logic [ID_W-1:0]               grant_dst,
    output logic                          req_err,
    output logic [15:0]                   grant_cnt
);

    localparam int unsigned REQ_W   = ID_W + 1;
    localparam logic [3:0]  HOLD_M1 = 4'(HOLD_CYCLES - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [2:0] CTRL_SEND = 3'b100;
    localparam logic [2:0] CTRL_RECV = 3'b010;
    localparam logic [2:0] CTRL_BYP  = 3'b001;

    logic [0:0]             state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [3:0]             hold_q, hold_d;
    logic [ID_W-1:0]        src_q, src_d;
    logic [ID_W-1:0]        dst_q, dst_d;
    logic [NUM_NODES*3-1:0] ctrl_q, ctrl_d;
    logic                   req_err_q, req_err_d;

    logic [NUM_NODES-1:0]   req_valid;
    logic [NUM_NODES-1:0]   eligible;
    logic [ID_W-1:0]        req_dst [NUM_NODES];

    logic                   pick_found;
    logic [ID_W-1:0]        pick_src;
    logic [ID_W-1:0]        pick_dst;
    logic [ID_W-1:0]        span_lo;
    logic [ID_W-1:0]        span_hi;
    logic [NUM_NODES*3-1:0] pick_ctrl;

    // Request decode: self-addressed or out-of-range destinations are not eligible.
    always_comb begin
        for (int k = 0; k < NUM_NODES; k++) begin
            req_valid[k] = req_in[k*REQ_W + ID_W];
            req_dst[k]   = req_in[k*REQ_W +: ID_W];
            eligible[k]  = req_valid[k] && (req_dst[k] != ID_W'(k))
                           && (32'(req_dst[k]) < NUM_NODES);
        end
    end

    // Round-robin scan: first pass covers rr_ptr..top, second pass wraps to 0..rr_ptr-1.
    always_comb begin
        pick_found = 1'b0;
        pick_src   = '0;
        pick_dst   = '0;
        for (int k = 0; k < NUM_NODES; k++) begin
            if (!pick_found && eligible[k] && (ID_W'(k) >= rr_ptr_q)) begin
                pick_found = 1'b1;
                pick_src   = ID_W'(k);
                pick_dst   = req_dst[k];
            end
        end
        for (int k = 0; k < NUM_NODES; k++) begin
            if (!pick_found && eligible[k]) begin
                pick_found = 1'b1;
                pick_src   = ID_W'(k);
                pick_dst   = req_dst[k];
            end
        end
    end

    // Channel path for the chosen pair: sender, receiver, and pass-through nodes between them.
    always_comb begin
        span_lo   = (pick_src < pick_dst) ? pick_src : pick_dst;
        span_hi   = (pick_src < pick_dst) ? pick_dst : pick_src;
        pick_ctrl = '0;
        for (int k = 0; k < NUM_NODES; k++) begin
            if (ID_W'(k) == pick_src) begin
                pick_ctrl[k*3 +: 3] = CTRL_SEND;
            end else if (ID_W'(k) == pick_dst) begin
                pick_ctrl[k*3 +: 3] = CTRL_RECV;
            end else if ((ID_W'(k) > span_lo) && (ID_W'(k) < span_hi)) begin
                pick_ctrl[k*3 +: 3] = CTRL_BYP;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        src_d     = src_q;
        dst_d     = dst_q;
        ctrl_d    = ctrl_q;
        req_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_err_d = |(req_valid & ~eligible);
                if (pick_found) begin
                    state_d = ST_GRANT;
                    src_d   = pick_src;
                    dst_d   = pick_dst;
                    ctrl_d  = pick_ctrl;
                    hold_d  = HOLD_M1;
                end
            end
            ST_GRANT: begin
                if (hold_q == 4'd0) begin
                    state_d  = ST_IDLE;
                    ctrl_d   = '0;
                    rr_ptr_d = (src_q == ID_W'(NUM_NODES - 1)) ? '0 : src_q + 1'b1;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ctrl_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            hold_q    <= 4'd0;
            src_q     <= '0;
            dst_q     <= '0;
            ctrl_q    <= '0;
            req_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            ctrl_q    <= ctrl_d;
            req_err_q <= req_err_d;
        end
    end

    assign ctrl_out  = ctrl_q;
    assign busy      = (state_q == ST_GRANT);
    assign grant_src = src_q;
    assign grant_dst = dst_q;
    assign req_err   = req_err_q;

`ifdef ARB_STATS_EN
    logic        grant_start;
    logic [15:0] grant_cnt_q;

    assign grant_start = (state_q == ST_IDLE) && pick_found;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_q <= 16'h0000;
        end else if (grant_start && (grant_cnt_q != 16'hFFFF)) begin
            grant_cnt_q <= grant_cnt_q + 16'd1;
        end
    end

    assign grant_cnt = grant_cnt_q;
`else
    assign grant_cnt = 16'h0000;
`endif

endmodule
